direct_cache_ctrl: RTL
======================

# direct_cache_ctrl

Sequencing controller for the 8-entry direct-mapped read cache (valid + 27-bit tag + 32-bit data per entry). It owns the tag/data arrays and accepts one CPU read at a time. Each read is resolved as a hit from the array or as a miss that is refilled from memory over a req/ack handshake. It also provides a sequenced invalidate-all (flush) and saturating hit/miss counters. It sits between the CPU load port and the memory bus.

## Interface
- ENTRY, 8, number of lines; power of two, minimum 2. INDEX_W = log2(ENTRY); tag width TAG_W = 30 - INDEX_W (27 at default).
- CNT_W, 16, width of hit/miss statistic counters.
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cpu_req  input  1  read request, level; sampled only in IDLE.
- cpu_addr  input  32  byte address; [1:0] ignored, index = [INDEX_W+1:2], tag = [31:INDEX_W+2].
- cpu_ready  output  1  one-cycle pulse: cpu_rdata/cpu_hit valid.
- cpu_rdata  output  32  read data, valid with cpu_ready, otherwise holds last value.
- cpu_hit  output  1  qualifies cpu_ready: 1 = hit, 0 = refilled miss.
- flush  input  1  one-cycle pulse request to invalidate all lines.
- flush_busy  output  1  high from flush acceptance until the last line is cleared.
- mem_req  output  1  refill request, held until mem_ack.
- mem_addr  output  32  {req_addr[31:2], 2'b00}, stable while mem_req.
- mem_ack  input  1  one-cycle pulse: mem_rdata valid this cycle.
- mem_rdata  input  32  refill data.
- hit_cnt, miss_cnt  output  CNT_W  saturating counts of completed hits/misses.

## Operation
- States: IDLE, LOOKUP, REFILL, RESP, FLUSH.
- IDLE: a pending flush (pulse or latched) has priority and moves the FSM to FLUSH. Otherwise, cpu_req=1 registers cpu_addr into req_addr and moves to LOOKUP.
- LOOKUP: index the arrays with req_addr.
  - On hit (valid and tag equal): pulse cpu_ready with cpu_hit=1 and cpu_rdata=entry data, increment hit_cnt, and return to IDLE.
  - On miss: go to REFILL.
- REFILL: drive mem_req=1 and mem_addr. On mem_ack: write entry[index] = {1, tag, mem_rdata}, capture mem_rdata into cpu_rdata, increment miss_cnt, and go to RESP.
- RESP: pulse cpu_ready with cpu_hit=0, then go to IDLE.
- FLUSH: a flush counter steps from 0 to ENTRY-1, clearing one valid bit per cycle. After the last line, clear flush_busy and go to IDLE. Data and tag contents are not cleared.
- Requester protocol:
  - Hold cpu_req until cpu_ready is seen.
  - cpu_addr need only be valid in the cycle the request is accepted.
  - If cpu_req is still high in the cycle after cpu_ready, it is a new request.
- Conflict miss (same index, different tag): the old line is overwritten; there is no write-back because the cache is read-only.
- A flush arriving outside IDLE is latched as pending, and flush_busy rises immediately. It runs after the current access completes (after RESP or a hit in LOOKUP). A second flush while one is pending or running is merged.
- mem_ack outside REFILL is ignored.
- Counters saturate at all-ones and do not wrap.

## Timing
- Reset values: state IDLE, all valid bits 0, cpu_ready 0, cpu_hit 0, cpu_rdata 0, mem_req 0, mem_addr 0, flush_busy 0, hit_cnt 0, miss_cnt 0, flush pending 0. Assertion of rst_n=0 takes effect immediately, including during REFILL, so mem_req drops asynchronously.
- Hit latency: request accepted at edge N, cpu_ready high in cycle N+1.
- Miss latency:
  - mem_req is high from cycle N+2.
  - If mem_ack arrives in cycle M, the array write and data capture happen at the end of M.
  - cpu_ready is high in cycle M+1.
  - mem_req is low from cycle M+1.
- Back-to-back hits accept a new request every 2 cycles (IDLE, LOOKUP).
- Flush from IDLE takes ENTRY cycles in FLUSH. For a pulse at edge N, flush_busy is high for cycles N+1 through N+ENTRY, and the next request is accepted at the earliest in cycle N+ENTRY+1.
- A refill write followed by a lookup of the same line sees the new data. There is no bypass hazard, because the lookup is at least 2 cycles later.

## Test plan
- Reset, then read 0x0000_1004 with mem_ack after 3 cycles and mem_rdata=0xDEAD_BEEF → mem_req with mem_addr 0x0000_1004; cpu_ready with cpu_hit=0 and rdata 0xDEAD_BEEF; miss_cnt=1.
- Re-read 0x0000_1006 → cpu_ready 1 cycle after acceptance, cpu_hit=1, rdata 0xDEAD_BEEF, no mem_req, hit_cnt=1.
- Read 0x0000_2004 (same index, new tag) → miss and refill; a subsequent read of 0x0000_1004 misses again.
- Pulse flush in IDLE after filling all 8 lines → flush_busy high for 8 cycles, then every one of the 8 addresses misses.
- Pulse flush during REFILL → flush_busy rises at once and the refill completes normally with cpu_ready. FLUSH then runs, and re-reading the refilled address misses.
- Assert rst_n=0 during REFILL → mem_req, cpu_ready and counters go to 0 immediately. A read after reset misses.
- With CNT_W=2, perform 5 hits → hit_cnt saturates at 3.

Source files
------------

// File: rtl/direct_cache_ctrl.sv
// direct_cache_ctrl
//   Sequencing controller for a small direct-mapped, read-only cache. It owns
//   the valid/tag/data arrays and serves one CPU read at a time. A read either
//   hits in the array or misses and is refilled from memory over a req/ack
//   handshake. It also runs a sequenced invalidate-all (flush) and keeps
//   saturating hit/miss statistics.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_req, cpu_addr     CPU read request (level) and byte address
//   cpu_ready             one-cycle pulse, cpu_rdata/cpu_hit valid
//   cpu_rdata, cpu_hit    read data and hit qualifier
//   flush, flush_busy     invalidate-all pulse and its busy indication
//   mem_req, mem_addr     refill request (held until mem_ack) and word address
//   mem_ack, mem_rdata    refill acknowledge pulse and data
//   hit_cnt, miss_cnt     saturating statistics counters
module direct_cache_ctrl #(
  parameter int ENTRY = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_addr,
  output logic             cpu_ready,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_hit,
  input  logic             flush,
  output logic             flush_busy,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int INDEX_W = $clog2(ENTRY);
  localparam int TAG_W   = 30 - INDEX_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REFILL = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;

  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ENTRY - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};

  // Saturating increment for the statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [2:0]         state_q,     state_d;
  logic [31:0]        req_addr_q,  req_addr_d;
  logic [ENTRY-1:0]   valid_q,     valid_d;
  logic [INDEX_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]        rdata_q,     rdata_d;
  logic               hit_q,       hit_d;
  logic               mem_req_q,   mem_req_d;
  logic [31:0]        mem_addr_q,  mem_addr_d;
  logic               busy_q,      busy_d;
  logic               pend_q,      pend_d;
  logic [CNT_W-1:0]   hit_cnt_q,   hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q,  miss_cnt_d;

  logic [TAG_W-1:0]   tag_q  [ENTRY];
  logic [31:0]        data_q [ENTRY];

  logic [INDEX_W-1:0] idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic               lookup_hit_s;
  logic               refill_wr_s;

  assign idx_s        = req_addr_q[INDEX_W+1:2];
  assign tag_s        = req_addr_q[31:INDEX_W+2];
  assign lookup_hit_s = (state_q == S_LOOKUP) && valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign refill_wr_s  = (state_q == S_REFILL) && mem_ack;

  // A hit is answered in the LOOKUP cycle itself, so the array data is
  // forwarded combinationally; otherwise the captured value is held. This
  // keeps the cycle after cpu_ready free to sample a new request.
  assign cpu_ready  = lookup_hit_s || (state_q == S_RESP);
  assign cpu_rdata  = lookup_hit_s ? data_q[idx_s] : rdata_q;
  assign cpu_hit    = lookup_hit_s || hit_q;
  assign flush_busy = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  // Next-state logic for the sequencing FSM, valid bits and statistics.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    valid_d     = valid_q;
    flush_cnt_d = flush_cnt_q;
    rdata_d     = rdata_q;
    hit_d       = hit_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    pend_d      = pend_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;

    case (state_q)
      S_IDLE: begin
        // A pending or fresh flush wins over a CPU request.
        if (flush || pend_q) begin
          state_d     = S_FLUSH;
          pend_d      = 1'b0;
          busy_d      = 1'b1;
          flush_cnt_d = {INDEX_W{1'b0}};
        end else if (cpu_req) begin
          req_addr_d = cpu_addr;
          state_d    = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit_s) begin
          rdata_d   = data_q[idx_s];
          hit_d     = 1'b1;
          hit_cnt_d = sat_inc(hit_cnt_q);
          state_d   = S_IDLE;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = {req_addr_q[31:2], 2'b00};
          state_d    = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ack) begin
          valid_d[idx_s] = 1'b1;
          rdata_d        = mem_rdata;
          hit_d          = 1'b0;
          miss_cnt_d     = sat_inc(miss_cnt_q);
          mem_req_d      = 1'b0;
          state_d        = S_RESP;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_FLUSH: begin
        valid_d[flush_cnt_q] = 1'b0;
        if (flush_cnt_q == LAST_IDX) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A flush during an access is remembered and runs once the access ends;
    // one arriving while a flush is already running is simply merged.
    if (flush && (state_q != S_IDLE) && (state_q != S_FLUSH)) begin
      pend_d = 1'b1;
      busy_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_addr_q  <= 32'h0000_0000;
      valid_q     <= {ENTRY{1'b0}};
      flush_cnt_q <= {INDEX_W{1'b0}};
      rdata_q     <= 32'h0000_0000;
      hit_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      hit_cnt_q   <= {CNT_W{1'b0}};
      miss_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      valid_q     <= valid_d;
      flush_cnt_q <= flush_cnt_d;
      rdata_q     <= rdata_d;
      hit_q       <= hit_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      pend_q      <= pend_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Tag/data storage; contents are only meaningful under a set valid bit,
  // so they need no reset and are left untouched by a flush.
  always_ff @(posedge clk) begin
    if (refill_wr_s) begin
      tag_q[idx_s]  <= tag_s;
      data_q[idx_s] <= mem_rdata;
    end else begin
      tag_q[idx_s]  <= tag_q[idx_s];
      data_q[idx_s] <= data_q[idx_s];
    end
  end

endmodule
